regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (regwrite / write_reg / write_data) between two writeback requesters: the ALU and the load/memory unit.
- Uses valid/ready handshakes with ALU-priority arbitration and a starvation guard for the memory requester.
- Holds the granted write in a one-entry output register, which also serves as a forwarding source for the decode stage.
- Sits between the execute/memory stages and the register file.

Parameters:
- DATA_W, 32, write data width.
- ADDR_W, 5, register index width.
- MAX_WAIT, 3, consecutive memory-request losses before memory is forced to win (legal range 1..15).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- alu_valid  in  1  ALU writeback request.
- alu_rd  in  ADDR_W  ALU destination register.
- alu_data  in  DATA_W  ALU result.
- alu_ready  out  1  ALU request accepted this cycle when alu_valid && alu_ready.
- mem_valid  in  1  load writeback request.
- mem_rd  in  ADDR_W  load destination register.
- mem_data  in  DATA_W  load data.
- mem_ready  out  1  load request accepted this cycle when mem_valid && mem_ready.
- wb_stall  in  1  freezes the output register; no register-file write occurs.
- regwrite  out  1  register-file write enable.
- write_reg  out  ADDR_W  register-file write index.
- write_data  out  DATA_W  register-file write data.
- fwd_valid  out  1  output register holds a pending write to a nonzero register.
- fwd_rd  out  ADDR_W  pending destination register, for forwarding.
- fwd_data  out  DATA_W  pending data, for forwarding.

Behaviour:
- Reset (async, active-high): out_valid=0, out_rd=0, out_data=0, wait_cnt=0, state=ALU_PRIO. All outputs read 0 while reset is high; alu_ready and mem_ready are 0.
- Output register: out_valid, out_rd, out_data. Drives write_reg=out_rd, write_data=out_data, fwd_rd=out_rd, fwd_data=out_data.
- regwrite = out_valid && !wb_stall && (out_rd != 0).
- fwd_valid = out_valid && (out_rd != 0).
- slot_free = !out_valid || !wb_stall. This is purely combinational and is the only back-pressure source.
- Grant is combinational within the cycle; at most one grant per cycle:
  - ALU_PRIO state: alu_valid wins; mem wins only when alu_valid=0.
  - MEM_FORCE state: mem_valid wins; ALU wins only when mem_valid=0.
- alu_ready = slot_free && grant_alu. mem_ready = slot_free && grant_mem. A requester with valid low sees ready low.
- On acceptance, the output register loads {1, rd, data} at the next edge. Latency from accept to regwrite is 1 cycle; wb_stall extends it.
- If slot_free && no request: out_valid <= 0 at the next edge.
- If wb_stall=1 && out_valid=1: the output register holds its contents, and both readies are 0.
- Writes to x0 are accepted and occupy the slot for a cycle, but regwrite stays 0 and fwd_valid stays 0.
- Starvation counter wait_cnt (4 bits):
  - Increments when mem_valid && slot_free && grant_alu, saturating at MAX_WAIT.
  - Clears to 0 on any memory acceptance.
  - Holds when slot_free=0, because a stall is not a lost arbitration.
- State transitions:
  - ALU_PRIO -> MEM_FORCE when wait_cnt reaches MAX_WAIT (takes effect the next cycle).
  - MEM_FORCE -> ALU_PRIO on a memory acceptance.
  - MEM_FORCE -> ALU_PRIO when mem_valid drops while state=MEM_FORCE and nothing was accepted from mem; wait_cnt clears.
- Requesters must hold valid, rd and data stable until accepted. The arbiter does not check this.
- Same rd from both requesters in consecutive cycles: the writes serialize in grant order, and the later grant overwrites the earlier one in the register file.

Decomposition:
- Shared package (riscv_pkg):
  - REG_ADDR_W=5, XLEN=32 constants.
  - wb_req_t struct {valid, rd, data}.
  - arb_state_e enum {ALU_PRIO, MEM_FORCE}.
- One sub-module, wb_out_reg: the one-entry output register plus the slot_free logic.
- Arbitration and the FSM stay in the top module.

Test Plan:
1. ALU only: alu_valid=1, rd=5, data=0xDEADBEEF, wb_stall=0 -> alu_ready=1 that cycle; next cycle regwrite=1, write_reg=5, write_data=0xDEADBEEF, fwd_valid=1.
2. Both valid for 5 cycles with MAX_WAIT=3 -> ALU accepted in cycles 0–2, mem accepted in cycle 3 (state MEM_FORCE), ALU accepted in cycle 4; wait_cnt=0 after cycle 3.
3. Stall: accept mem rd=7 data=0x11, then wb_stall=1 for 3 cycles with alu_valid=1 -> alu_ready=0 and regwrite=0 throughout; out_rd holds 7. On release, regwrite=1 with write_reg=7; ALU accepted the same cycle.
4. x0 write: alu_valid rd=0 data=0xFFFFFFFF -> accepted; next cycle regwrite=0 and fwd_valid=0; slot drains the following cycle.
5. Reset mid-operation: assert reset asynchronously while out_valid=1 and state=MEM_FORCE -> regwrite, fwd_valid and both readies go to 0 immediately. After release, ALU-priority arbitration holds with wait_cnt=0.
6. Mem request withdrawn in MEM_FORCE: reach MEM_FORCE, drop mem_valid, alu_valid=1 -> ALU accepted, state returns to ALU_PRIO, wait_cnt=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the register-file writeback path.
//   REG_ADDR_W / XLEN : default register index and data widths
//   WAIT_W            : width of the memory starvation counter
//   wb_req_t          : writeback request {valid, rd, data} at default widths
//   arb_state_e       : arbitration priority state
//   sat_inc           : saturating increment for the starvation counter
package riscv_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int XLEN       = 32;
   localparam int WAIT_W     = 4;

   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } wb_req_t;

   typedef enum logic {
      ALU_PRIO  = 1'b0,
      MEM_FORCE = 1'b1
   } arb_state_e;

   function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] v,
                                                 input logic [WAIT_W-1:0] lim);
      return (v >= lim) ? lim : v + WAIT_W'(1);
   endfunction

endpackage

// File: rtl/wb_out_reg.sv
// One-entry writeback output register.
//   clock, reset          : rising-edge clock, async active-high reset
//   load/load_rd/load_data: accepted write, captured at the next edge
//   wb_stall              : freezes a held entry
//   out_valid/rd/data     : held write
//   slot_free             : register can take a new write this cycle
module wb_out_reg #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              load,
   input  logic [ADDR_W-1:0] load_rd,
   input  logic [DATA_W-1:0] load_data,
   input  logic              wb_stall,
   output logic              out_valid,
   output logic [ADDR_W-1:0] out_rd,
   output logic [DATA_W-1:0] out_data,
   output logic              slot_free
);

   // A stall only matters when something is actually held.
   assign slot_free = !out_valid || !wb_stall;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_rd    <= '0;
         out_data  <= '0;
      end else if (slot_free) begin
         out_valid <= load;
         if (load) begin
            out_rd   <= load_rd;
            out_data <= load_data;
         end
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between the ALU and the
// load unit. ALU has priority; after MAX_WAIT consecutive lost arbitrations
// the memory requester is given priority until it is served or withdraws.
//   clock, reset               : rising-edge clock, async active-high reset
//   alu_valid/rd/data, ready   : ALU writeback handshake
//   mem_valid/rd/data, ready   : load writeback handshake
//   wb_stall                   : freezes the output register
//   regwrite/write_reg/data    : register-file write port
//   fwd_valid/fwd_rd/fwd_data  : pending write for decode-stage forwarding
module regfile_wb_arbiter
   import riscv_pkg::*;
#(
   parameter int DATA_W   = XLEN,
   parameter int ADDR_W   = REG_ADDR_W,
   parameter int MAX_WAIT = 3
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              alu_valid,
   input  logic [ADDR_W-1:0] alu_rd,
   input  logic [DATA_W-1:0] alu_data,
   output logic              alu_ready,
   input  logic              mem_valid,
   input  logic [ADDR_W-1:0] mem_rd,
   input  logic [DATA_W-1:0] mem_data,
   output logic              mem_ready,
   input  logic              wb_stall,
   output logic              regwrite,
   output logic [ADDR_W-1:0] write_reg,
   output logic [DATA_W-1:0] write_data,
   output logic              fwd_valid,
   output logic [ADDR_W-1:0] fwd_rd,
   output logic [DATA_W-1:0] fwd_data
);

   localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT);

   arb_state_e        state, state_nxt;
   logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
   logic              grant_alu, grant_mem;
   logic              alu_acc, mem_acc;
   logic              slot_free;
   logic              out_valid;
   logic [ADDR_W-1:0] out_rd;
   logic [DATA_W-1:0] out_data;

   // Grant is a pure function of the current priority state and the valids.
   always_comb begin
      grant_alu = 1'b0;
      grant_mem = 1'b0;
      if (state == ALU_PRIO) begin
         grant_alu = alu_valid;
         grant_mem = mem_valid && !alu_valid;
      end else begin
         grant_mem = mem_valid;
         grant_alu = alu_valid && !mem_valid;
      end
   end

   // Readies are forced low while reset is asserted, even though the slot
   // reads as free then.
   assign alu_ready = !reset && slot_free && grant_alu;
   assign mem_ready = !reset && slot_free && grant_mem;
   assign alu_acc   = alu_ready;
   assign mem_acc   = mem_ready;

   wb_out_reg #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_out (
      .clock     (clock),
      .reset     (reset),
      .load      (alu_acc || mem_acc),
      .load_rd   (mem_acc ? mem_rd   : alu_rd),
      .load_data (mem_acc ? mem_data : alu_data),
      .wb_stall  (wb_stall),
      .out_valid (out_valid),
      .out_rd    (out_rd),
      .out_data  (out_data),
      .slot_free (slot_free)
   );

   assign write_reg  = out_rd;
   assign write_data = out_data;
   assign fwd_rd     = out_rd;
   assign fwd_data   = out_data;
   assign fwd_valid  = out_valid && (out_rd != '0);
   assign regwrite   = out_valid && !wb_stall && (out_rd != '0);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= ALU_PRIO;
         wait_cnt <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
      end
   end

   // The counter only moves on a real lost arbitration; a stalled slot is
   // not a loss. Switching on the updated count lets memory win in the very
   // cycle after its MAX_WAIT-th loss.
   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      if (mem_acc)
         wait_cnt_nxt = '0;
      else if (mem_valid && slot_free && grant_alu)
         wait_cnt_nxt = sat_inc(wait_cnt, WAIT_LIM);
      case (state)
         ALU_PRIO: begin
            if (wait_cnt_nxt == WAIT_LIM)
               state_nxt = MEM_FORCE;
         end
         MEM_FORCE: begin
            if (mem_acc) begin
               state_nxt = ALU_PRIO;
            end else if (!mem_valid) begin
               // Requester withdrew; its starvation history no longer applies.
               state_nxt    = ALU_PRIO;
               wait_cnt_nxt = '0;
            end
         end
         default: state_nxt = ALU_PRIO;
      endcase
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

   localparam int DW = 32;
   localparam int AW = 5;

   logic          clock = 1'b0;
   logic          reset;
   logic          alu_valid, mem_valid, wb_stall;
   logic [AW-1:0] alu_rd, mem_rd;
   logic [DW-1:0] alu_data, mem_data;
   logic          alu_ready, mem_ready, regwrite, fwd_valid;
   logic [AW-1:0] write_reg, fwd_rd;
   logic [DW-1:0] write_data, fwd_data;

   int checks = 0;
   int errors = 0;

   regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MAX_WAIT(3)) dut (
      .clock      (clock),
      .reset      (reset),
      .alu_valid  (alu_valid),
      .alu_rd     (alu_rd),
      .alu_data   (alu_data),
      .alu_ready  (alu_ready),
      .mem_valid  (mem_valid),
      .mem_rd     (mem_rd),
      .mem_data   (mem_data),
      .mem_ready  (mem_ready),
      .wb_stall   (wb_stall),
      .regwrite   (regwrite),
      .write_reg  (write_reg),
      .write_data (write_data),
      .fwd_valid  (fwd_valid),
      .fwd_rd     (fwd_rd),
      .fwd_data   (fwd_data)
   );

   always #5 clock = ~clock;

   // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      alu_valid = 1'b0;
      mem_valid = 1'b0;
      wb_stall  = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle();
      alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h1234;
      mem_valid = 1'b1; mem_rd = 5'd6; mem_data = 32'h5678;
      step();
      checks++; if (alu_ready !== 1'b0) begin errors++; $display("FAIL rst_alu_ready got %0b exp 0", alu_ready); end
      checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL rst_mem_ready got %0b exp 0", mem_ready); end
      checks++; if (regwrite !== 1'b0) begin errors++; $display("FAIL rst_regwrite got %0b exp 0", regwrite); end
      checks++; if (fwd_valid !== 1'b0) begin errors++; $display("FAIL rst_fwd_valid got %0b exp 0", fwd_valid); end
      checks++; if (write_reg !== 5'd0 || write_data !== 32'd0) begin errors++; $display("FAIL rst_write got %0d/%h exp 0/0", write_reg, write_data); end
      idle();
      reset = 1'b0;
      step();
   endtask

   task automatic test_alu_only();
      idle();
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
      #1;
      checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL alu_only_ready got %0b exp 1", alu_ready); end
      checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL alu_only_mem_ready got %0b exp 0", mem_ready); end
      step();
      alu_valid = 1'b0;
      #1;
      checks++; if (regwrite !== 1'b1) begin errors++; $display("FAIL alu_only_regwrite got %0b exp 1", regwrite); end
      checks++; if (write_reg !== 5'd5) begin errors++; $display("FAIL alu_only_write_reg got %0d exp 5", write_reg); end
      checks++; if (write_data !== 32'hDEADBEEF) begin errors++; $display("FAIL alu_only_write_data got %h exp deadbeef", write_data); end
      checks++; if (fwd_valid !== 1'b1 || fwd_rd !== 5'd5) begin errors++; $display("FAIL alu_only_fwd got %0b/%0d exp 1/5", fwd_valid, fwd_rd); end
      step();
      checks++; if (regwrite !== 1'b0) begin errors++; $display("FAIL alu_only_drain got %0b exp 0", regwrite); end
   endtask

   task automatic test_starvation();
      logic [4:0] exp_alu;
      exp_alu = 5'b10111; // bit i: ALU wins in cycle i
      idle();
      alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'hA0;
      mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h99;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++;
         if (alu_ready !== exp_alu[i] || mem_ready !== !exp_alu[i]) begin
            errors++;
            $display("FAIL starve_grant_c%0d got alu=%0b mem=%0b exp alu=%0b", i, alu_ready, mem_ready, exp_alu[i]);
         end
         step();
         if (i == 3) begin
            checks++; if (write_reg !== 5'd9 || write_data !== 32'h99) begin errors++; $display("FAIL starve_mem_write got %0d/%h exp 9/99", write_reg, write_data); end
         end
      end
      idle();
      step();
   endtask

   task automatic test_stall();
      idle();
      mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h11;
      #1;
      checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL stall_mem_accept got %0b exp 1", mem_ready); end
      step();
      mem_valid = 1'b0;
      wb_stall  = 1'b1;
      alu_valid = 1'b1; alu_rd = 5'd8; alu_data = 32'h22;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (alu_ready !== 1'b0 || regwrite !== 1'b0 || fwd_rd !== 5'd7) begin
            errors++;
            $display("FAIL stall_hold_c%0d got rdy=%0b rw=%0b rd=%0d exp 0/0/7", i, alu_ready, regwrite, fwd_rd);
         end
         step();
      end
      wb_stall = 1'b0;
      #1;
      checks++; if (regwrite !== 1'b1 || write_reg !== 5'd7 || write_data !== 32'h11) begin errors++; $display("FAIL stall_release got rw=%0b rd=%0d d=%h exp 1/7/11", regwrite, write_reg, write_data); end
      checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL stall_release_alu got %0b exp 1", alu_ready); end
      step();
      alu_valid = 1'b0;
      #1;
      checks++; if (write_reg !== 5'd8 || regwrite !== 1'b1) begin errors++; $display("FAIL stall_alu_write got %0d/%0b exp 8/1", write_reg, regwrite); end
      step();
   endtask

   task automatic test_x0();
      idle();
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFFFFFF;
      #1;
      checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL x0_accept got %0b exp 1", alu_ready); end
      step();
      alu_valid = 1'b0;
      #1;
      checks++; if (regwrite !== 1'b0 || fwd_valid !== 1'b0) begin errors++; $display("FAIL x0_suppress got rw=%0b fv=%0b exp 0/0", regwrite, fwd_valid); end
      step();
      // Slot must have drained: a stalled cycle still accepts.
      wb_stall = 1'b1;
      alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
      #1;
      checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL x0_drained got %0b exp 1", alu_ready); end
      step();
      alu_valid = 1'b0;
      #1;
      checks++; if (regwrite !== 1'b0 || fwd_valid !== 1'b1 || fwd_rd !== 5'd3) begin errors++; $display("FAIL x0_stalled_fwd got rw=%0b fv=%0b rd=%0d exp 0/1/3", regwrite, fwd_valid, fwd_rd); end
      wb_stall = 1'b0;
      #1;
      checks++; if (regwrite !== 1'b1 || write_data !== 32'h33) begin errors++; $display("FAIL x0_unstall got rw=%0b d=%h exp 1/33", regwrite, write_data); end
      step();
   endtask

   // Both valid: ALU should win three times, then memory once.
   task automatic run_fair_pattern(input string tag);
      logic [3:0] exp_alu;
      exp_alu = 4'b0111;
      alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'hC0;
      mem_valid = 1'b1; mem_rd = 5'd13; mem_data = 32'hD0;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++;
         if (alu_ready !== exp_alu[i] || mem_ready !== !exp_alu[i]) begin
            errors++;
            $display("FAIL %s_c%0d got alu=%0b mem=%0b exp alu=%0b", tag, i, alu_ready, mem_ready, exp_alu[i]);
         end
         step();
      end
      idle();
      step();
   endtask

   task automatic test_withdraw();
      idle();
      alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'hB0;
      mem_valid = 1'b1; mem_rd = 5'd11; mem_data = 32'hB1;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL withdraw_pre_c%0d got %0b exp 1", i, alu_ready); end
         step();
      end
      mem_valid = 1'b0;
      #1;
      checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL withdraw_alu got %0b exp 1", alu_ready); end
      step();
      run_fair_pattern("withdraw_after");
   endtask

   task automatic test_reset_mid();
      idle();
      alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h44;
      mem_valid = 1'b1; mem_rd = 5'd14; mem_data = 32'hE0;
      for (int i = 0; i < 3; i++) step();
      alu_valid = 1'b1;
      #1;
      checks++; if (fwd_valid !== 1'b1 || mem_ready !== 1'b1) begin errors++; $display("FAIL rmid_pre got fv=%0b mrdy=%0b exp 1/1", fwd_valid, mem_ready); end
      #1 reset = 1'b1;
      #1;
      checks++;
      if (regwrite !== 1'b0 || fwd_valid !== 1'b0 || alu_ready !== 1'b0 || mem_ready !== 1'b0) begin
         errors++;
         $display("FAIL rmid_async got rw=%0b fv=%0b ar=%0b mr=%0b exp 0000", regwrite, fwd_valid, alu_ready, mem_ready);
      end
      step();
      reset = 1'b0;
      run_fair_pattern("rmid_after");
   endtask

   initial begin
      idle();
      alu_rd = '0; alu_data = '0; mem_rd = '0; mem_data = '0;
      test_reset();
      test_alu_only();
      test_starvation();
      test_stall();
      test_x0();
      test_withdraw();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
